// File: rtl/step_move_ctrl.sv
// Move sequencer for a 4-phase unipolar stepper: step count, rate, direction, full/half mode, position.
// Build option: define STEP_PHASE_OFF_EN to release the coils (phase = 0000) when the sequencer returns to idle.
module step_move_ctrl #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned PER_W = 16
) (
    input  logic             clk,
    input  logic             xres,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             half,
    input  logic [PER_W-1:0] period,
    input  logic [CNT_W-1:0] steps,
    output logic             busy,
    output logic             done,
    output logic             step_pulse,
    output logic [3:0]       phase,
    output logic [CNT_W-1:0] pos
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic             s1, s2, start_p;
    logic             dir_l, half_l;
    logic [PER_W-1:0] period_l, timer;
    logic [CNT_W-1:0] remaining;
    logic [2:0]       idx, idx_step;
    logic             tc, do_load, do_step;

    // Half-step coil table; even entries are one-phase, odd entries two-phase.
    function automatic logic [3:0] tbl(input logic [2:0] i);
        case (i)
            3'd0:    tbl = 4'b0001;
            3'd1:    tbl = 4'b0011;
            3'd2:    tbl = 4'b0010;
            3'd3:    tbl = 4'b0110;
            3'd4:    tbl = 4'b0100;
            3'd5:    tbl = 4'b1100;
            3'd6:    tbl = 4'b1000;
            default: tbl = 4'b1001;
        endcase
    endfunction

    assign start_p  = s1 & ~s2;
    assign tc       = (timer == period_l - PER_W'(1));
    assign idx_step = dir_l ? idx + (half_l ? 3'd1 : 3'd2)
                            : idx - (half_l ? 3'd1 : 3'd2);

    always_ff @(posedge clk or negedge xres) begin
        if (!xres) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state plus load/step strobes; stop in RUN suppresses a coincident step.
    always_comb begin
        state_nxt = state;
        do_load   = 1'b0;
        do_step   = 1'b0;
        case (state)
            IDLE: if (start_p) state_nxt = LOAD;
            LOAD: begin
                do_load   = 1'b1;
                state_nxt = (steps == '0) ? DONE : RUN;
            end
            RUN: begin
                if (stop) begin
                    state_nxt = DONE;
                end else if (tc) begin
                    do_step = 1'b1;
                    if (remaining == CNT_W'(1)) state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge xres) begin
        if (!xres) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            step_pulse <= 1'b0;
            phase      <= 4'b0000;
            pos        <= '0;
            idx        <= 3'd0;
            dir_l      <= 1'b0;
            half_l     <= 1'b0;
            period_l   <= PER_W'(1);
            timer      <= '0;
            remaining  <= '0;
        end else begin
            s1         <= start;
            s2         <= s1;
            busy       <= (state_nxt == LOAD) || (state_nxt == RUN);
            done       <= (state_nxt == DONE);
            step_pulse <= do_step;
            if (state == IDLE && start_p) phase <= tbl(idx);
            if (do_load) begin
                dir_l     <= dir;
                half_l    <= half;
                period_l  <= (period == '0) ? PER_W'(1) : period;
                remaining <= steps;
                timer     <= '0;
            end else if (state == RUN) begin
                timer <= tc ? '0 : timer + PER_W'(1);
            end
            if (do_step) begin
                idx       <= idx_step;
                phase     <= tbl(idx_step);
                pos       <= dir_l ? pos + CNT_W'(1) : pos - CNT_W'(1);
                remaining <= remaining - CNT_W'(1);
            end
`ifdef STEP_PHASE_OFF_EN
            if (state == DONE) phase <= 4'b0000;
`else
`endif
        end
    end

endmodule
